// File: rtl/proj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proj_pkg
//  Description : Shared types and default constants for the front-end pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================

package proj_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned INC_DEF      = 4;

    // Next value of a saturating up-counter of up to 32 bits.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value,
                                              input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : Generic pipeline register with load enable and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================

module pipe_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear wins over load so a squash can never be overwritten in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: PC, next-PC selection, IF/ID register and
//                fetch/bubble performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================

module fetch_stage
    import proj_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned        INC      = INC_DEF,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] instr,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic [DATA_W-1:0] if_id_instr,
    output logic              if_id_valid,
    output logic              misalign,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [ADDR_W-1:0] C_INC      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] C_LOW_MASK = ADDR_W'(INC - 1);
    localparam int unsigned       C_IFID_W   = 2 * ADDR_W + DATA_W + 1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q,         pc_d;
    logic                misalign_q,   misalign_d;
    logic [CNT_W-1:0]    fetch_cnt_q,  fetch_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

    logic                w_redirect;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_target_aligned;
    logic                w_target_misaligned;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_pc_advance;
    logic                w_load;
    logic                w_bubble;
    logic [C_IFID_W-1:0] w_ifid_d;
    logic [C_IFID_W-1:0] w_ifid_q;

    assign w_redirect          = jump | branch_taken;
    assign w_target            = jump ? jump_target : branch_target;
    assign w_target_aligned    = w_target & ~C_LOW_MASK;
    assign w_target_misaligned = |(w_target & C_LOW_MASK);
    assign w_pc_inc            = pc_q + C_INC;

    // Redirect outranks stall; stall outranks flush and memory wait.
    assign w_pc_advance = !w_redirect && !stall && imem_valid;
    assign w_load       = !w_redirect && !stall && !flush && imem_valid;
    assign w_bubble     = w_redirect || flush || (!stall && !imem_valid);

    always_comb begin
        pc_d         = pc_q;
        misalign_d   = misalign_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (w_redirect) begin
            pc_d       = w_target_aligned;
            misalign_d = misalign_q | w_target_misaligned;
        end else if (w_pc_advance) begin
            pc_d = w_pc_inc;
        end

        if (w_load && (fetch_cnt_q != C_CNT_MAX)) begin
            fetch_cnt_d = fetch_cnt_q + C_CNT_ONE;
        end
        if (w_bubble && (bubble_cnt_q != C_CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            misalign_q   <= misalign_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Fetch state tracks whether the last cycle was starved by memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!w_redirect && !stall && !imem_valid) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_redirect || (!stall && imem_valid)) begin
                        state_q <= FETCH;
                    end
                end
            endcase
        end
    end

    assign w_ifid_d = {pc_q, w_pc_inc, instr, 1'b1};

    pipe_reg #(
        .WIDTH (C_IFID_W)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .en_i  (w_load),
        .clr_i (w_bubble),
        .d_i   (w_ifid_d),
        .q_o   (w_ifid_q)
    );

    assign {if_id_pc, if_id_pc_next, if_id_instr, if_id_valid} = w_ifid_q;

    assign inst_addr    = pc_q;
    assign misalign     = misalign_q;
    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage (wide and 2-bit counters).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_fetch_stage;

    localparam logic [31:0] C_RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] a_addr, a_pc, a_pcn, a_instr;
    logic        a_valid, a_mis;
    logic [15:0] a_fc, a_bc;
    logic [31:0] b_addr, b_pc, b_pcn, b_instr;
    logic        b_valid, b_mis;
    logic [1:0]  b_fc, b_bc;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(C_RPC), .INC(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .inst_addr(a_addr), .instr(instr), .imem_valid(imem_valid),
        .stall(stall), .flush(flush), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_pc(a_pc), .if_id_pc_next(a_pcn), .if_id_instr(a_instr), .if_id_valid(a_valid),
        .misalign(a_mis), .fetch_count(a_fc), .bubble_count(a_bc));

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(C_RPC), .INC(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .inst_addr(b_addr), .instr(instr), .imem_valid(imem_valid),
        .stall(stall), .flush(flush), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_pc(b_pc), .if_id_pc_next(b_pcn), .if_id_instr(b_instr), .if_id_valid(b_valid),
        .misalign(b_mis), .fetch_count(b_fc), .bubble_count(b_bc));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state evolved by the priority rules.
    logic [31:0] m_pc, m_id_pc, m_id_instr;
    bit          m_id_valid, m_mis;
    int          m_fc, m_bc;

    task automatic model_reset();
        m_pc = C_RPC; m_id_pc = '0; m_id_instr = '0;
        m_id_valid = 0; m_mis = 0; m_fc = 0; m_bc = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = jump ? jump_target : branch_target;
        if (jump || branch_taken) begin
            if (tgt % 4 != 0) m_mis = 1;
            m_pc = tgt - (tgt % 4);
            m_id_valid = 0; m_bc++;
        end else if (stall) begin
            if (flush) begin m_id_valid = 0; m_bc++; end
        end else if (flush) begin
            m_id_valid = 0; m_bc++;
            if (imem_valid) m_pc = m_pc + 4;
        end else if (!imem_valid) begin
            m_id_valid = 0; m_bc++;
        end else begin
            m_id_pc = m_pc; m_id_instr = instr; m_id_valid = 1; m_fc++;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; jump = 0; branch_taken = 0; imem_valid = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst = 1'b1;
        #2;
        model_reset();
        n_checks++; if (a_addr !== C_RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", a_addr, C_RPC); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_checks++; if (a_pc !== 32'h0 || a_instr !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: got pc %h instr %h want 0", a_pc, a_instr); end
        n_checks++; if (a_fc !== 16'd0 || a_bc !== 16'd0 || a_mis !== 1'b0) begin n_fail++; $display("FAIL reset_counters: got fc %0d bc %0d mis %b want 0", a_fc, a_bc, a_mis); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            instr = words[i];
            tick();
            n_checks++; if (a_addr !== C_RPC + 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, a_addr, C_RPC + 32'(4 * (i + 1))); end
            n_checks++; if (a_valid !== 1'b1 || a_pc !== C_RPC + 32'(4 * i) || a_instr !== words[i]) begin n_fail++; $display("FAIL seq_ifid%0d: got v%b pc %h instr %h want pc %h instr %h", i, a_valid, a_pc, a_instr, C_RPC + 32'(4 * i), words[i]); end
            n_checks++; if (a_pcn !== C_RPC + 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_pcnext%0d: got %h want %h", i, a_pcn, C_RPC + 32'(4 * (i + 1))); end
        end
        n_checks++; if (a_fc !== 16'd3) begin n_fail++; $display("FAIL seq_fetch_count: got %0d want 3", a_fc); end
    endtask

    task automatic test_wait();
        logic [15:0] bc0;
        logic [31:0] w;
        clear_inputs();
        jump = 1; jump_target = 32'h8;
        tick();
        jump = 0;
        n_checks++; if (a_addr !== 32'h8) begin n_fail++; $display("FAIL wait_jump: got %h want 8", a_addr); end
        bc0 = a_bc;
        imem_valid = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (a_addr !== 32'h8 || a_valid !== 1'b0) begin n_fail++; $display("FAIL wait_hold%0d: got addr %h v%b want 8 v0", i, a_addr, a_valid); end
        end
        n_checks++; if (a_bc !== bc0 + 16'd2) begin n_fail++; $display("FAIL wait_bubbles: got %0d want %0d", a_bc, bc0 + 16'd2); end
        imem_valid = 1; w = $urandom; instr = w;
        tick();
        n_checks++; if (a_valid !== 1'b1 || a_pc !== 32'h8 || a_instr !== w || a_addr !== 32'hC) begin n_fail++; $display("FAIL wait_deliver: got v%b pc %h instr %h addr %h want pc 8 instr %h addr c", a_valid, a_pc, a_instr, a_addr, w); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        logic [15:0] fc0, bc0;
        clear_inputs();
        instr = 32'hDEADBEEF;
        tick();
        pc0 = a_addr; fc0 = a_fc; bc0 = a_bc;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            instr = $urandom;
            tick();
            n_checks++; if (a_addr !== pc0 || a_instr !== 32'hDEADBEEF || a_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got addr %h instr %h v%b want %h deadbeef v1", i, a_addr, a_instr, a_valid, pc0); end
            n_checks++; if (a_fc !== fc0 || a_bc !== bc0) begin n_fail++; $display("FAIL stall_counters%0d: got %0d/%0d want %0d/%0d", i, a_fc, a_bc, fc0, bc0); end
        end
        stall = 0;
        tick();
        n_checks++; if (a_pc !== pc0 || a_addr !== pc0 + 32'd4 || a_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got pc %h addr %h v%b want pc %h", a_pc, a_addr, a_valid, pc0); end
    endtask

    task automatic test_redirect_priority();
        clear_inputs();
        jump = 1; jump_target = 32'h400;
        branch_taken = 1; branch_target = 32'h200;
        stall = 1;
        tick();
        clear_inputs();
        n_checks++; if (a_addr !== 32'h400 || a_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_prio: got addr %h v%b want 400 v0", a_addr, a_valid); end
    endtask

    task automatic test_misalign();
        clear_inputs();
        do_reset();
        n_checks++; if (a_mis !== 1'b0) begin n_fail++; $display("FAIL mis_initial: got %b want 0", a_mis); end
        branch_taken = 1; branch_target = 32'h203;
        tick();
        branch_taken = 0;
        n_checks++; if (a_addr !== 32'h200 || a_mis !== 1'b1) begin n_fail++; $display("FAIL mis_set: got addr %h mis %b want 200 1", a_addr, a_mis); end
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (a_mis !== 1'b1 || a_addr !== 32'h20C) begin n_fail++; $display("FAIL mis_sticky: got mis %b addr %h want 1 20c", a_mis, a_addr); end
        do_reset();
        n_checks++; if (a_mis !== 1'b0) begin n_fail++; $display("FAIL mis_reset: got %b want 0", a_mis); end
    endtask

    task automatic test_wrap_saturate();
        clear_inputs();
        do_reset();
        jump = 1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 0;
        tick();
        n_checks++; if (a_addr !== 32'h0 || a_pc !== 32'hFFFF_FFFC || a_pcn !== 32'h0) begin n_fail++; $display("FAIL wrap: got addr %h pc %h pcn %h want 0 fffffffc 0", a_addr, a_pc, a_pcn); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (a_fc !== 16'd5) begin n_fail++; $display("FAIL sat_wide: got %0d want 5", a_fc); end
        n_checks++; if (b_fc !== 2'd3) begin n_fail++; $display("FAIL sat_narrow: got %0d want 3", b_fc); end
    endtask

    task automatic test_reset_midwait();
        clear_inputs();
        imem_valid = 0;
        tick(); tick();
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (a_addr !== C_RPC || a_bc !== 16'd0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_reset: got addr %h bc %0d v%b want %h 0 0", a_addr, a_bc, a_valid, C_RPC); end
        #1 rst = 1'b0;
        imem_valid = 1;
        tick();
        n_checks++; if (a_pc !== C_RPC || a_valid !== 1'b1 || a_addr !== C_RPC + 32'd4) begin n_fail++; $display("FAIL midwait_first: got pc %h v%b addr %h want %h", a_pc, a_valid, a_addr, C_RPC); end
    endtask

    task automatic test_random();
        logic [31:0] t;
        logic [15:0] e_fc, e_bc;
        logic [1:0]  s_fc, s_bc;
        for (int i = 0; i < 400; i++) begin
            imem_valid   = ($urandom_range(9) < 8);
            stall        = ($urandom_range(9) < 2);
            flush        = ($urandom_range(9) < 1);
            jump         = ($urandom_range(19) < 1);
            branch_taken = ($urandom_range(11) < 1);
            t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            jump_target = t;
            t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            branch_target = t;
            instr = $urandom;
            tick();
            e_fc = (m_fc > 65535) ? 16'hFFFF : 16'(m_fc);
            e_bc = (m_bc > 65535) ? 16'hFFFF : 16'(m_bc);
            s_fc = (m_fc > 3) ? 2'd3 : 2'(m_fc);
            s_bc = (m_bc > 3) ? 2'd3 : 2'(m_bc);
            n_checks++; if (a_addr !== m_pc || b_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h/%h want %h", i, a_addr, b_addr, m_pc); end
            n_checks++; if (a_valid !== m_id_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, a_valid, m_id_valid); end
            if (m_id_valid) begin
                n_checks++; if (a_pc !== m_id_pc || a_pcn !== m_id_pc + 32'd4 || a_instr !== m_id_instr) begin n_fail++; $display("FAIL rnd_ifid@%0d: got pc %h pcn %h instr %h want %h %h %h", i, a_pc, a_pcn, a_instr, m_id_pc, m_id_pc + 32'd4, m_id_instr); end
            end
            n_checks++; if (a_mis !== m_mis) begin n_fail++; $display("FAIL rnd_mis@%0d: got %b want %b", i, a_mis, m_mis); end
            n_checks++; if (a_fc !== e_fc || a_bc !== e_bc) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, a_fc, a_bc, e_fc, e_bc); end
            n_checks++; if (b_fc !== s_fc || b_bc !== s_bc) begin n_fail++; $display("FAIL rnd_satcnt@%0d: got %0d/%0d want %0d/%0d", i, b_fc, b_bc, s_fc, s_bc); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_redirect_priority();
        test_misalign();
        test_wrap_saturate();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
